// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for a given pass count; never narrower than one bit.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder slice shared across all nibble passes.
module nibble_add4
    import serial_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SLICE_W];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: one 4-bit slice reused LSB-first, carry held in a register.
// Define SERIAL_ADD_SUB_EN to honour the sub input (A-B via inverted B, carry-in 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / SLICE_W;
    localparam int CNT_W   = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr, b_sr, sum_r;
    logic             cout_r;

    logic [WIDTH-1:0]   b_load;
    logic               cin_load;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               accept;

`ifdef SERIAL_ADD_SUB_EN
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign cin_load   = cin;
`endif

    assign accept = in_valid && (state == IDLE);

    nibble_add4 u_slice (
        .a    (a_sr[SLICE_W-1:0]),
        .b    (b_sr[SLICE_W-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)    state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    if (out_ready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pass counter, inter-nibble carry and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= cin_load;
        end else if (state == RUN) begin
            sum_r[int'(cnt)*SLICE_W +: SLICE_W] <= slice_sum;
            carry <= slice_cout;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) cout_r <= slice_cout;
        end
    end

    // Operand shift registers feed the slice from their low nibble; no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr <= a;
            b_sr <= b_load;
        end else if (state == RUN) begin
            a_sr <= a_sr >> SLICE_W;
            b_sr <= b_sr >> SLICE_W;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed checks of serial_add_ctrl against a whole-word arithmetic model.
module tb_serial_add_ctrl;

    localparam int W = 16;
    localparam int NIB = W / 4;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int tests = 0;
    int failed = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Whole-word reference: {cout, sum} of A+B+cin, or A-B when subtract is enabled
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic sb);
        logic [W:0] add_r, sub_r;
        add_r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
        sub_r = {1'b0, av} + {1'b0, ~bv} + {{W{1'b0}}, 1'b1};
        return (SUB_EN && sb) ? sub_r : add_r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for out_valid; does not complete the handshake
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input logic sb, input bit toggle,
                         output logic [W-1:0] s, output logic co, output int lat,
                         output bit rdy_low, output bit ok);
        int waitc = 0;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        a = av; b = bv; cin = ci; sub = sb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        rdy_low = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready) rdy_low = 1'b0;
            if (toggle) begin
                a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        ok = out_valid;
        s = sum;
        co = cout;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
        tests++;
        if (sum !== '0 || cout !== 1'b0) begin
            failed++;
            $display("FAIL reset_data: sum=%h cout=%b, required 0000 0", sum, cout);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] av[3] = '{16'h1234, 16'hFFFF, 16'h0000};
        logic [W-1:0] bv[3] = '{16'h0FFF, 16'h0001, 16'h0000};
        logic         cv[3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es[3] = '{16'h2233, 16'h0000, 16'h0001};
        logic         ec[3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] s;
        logic co;
        int lat;
        bit rl, ok;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], cv[i], 1'b0, 1'b0, s, co, lat, rl, ok);
            tests++;
            if (!ok || lat != NIB) begin
                failed++;
                $display("FAIL directed_latency[%0d]: valid=%b after %0d cycles, required %0d",
                         i, ok, lat, NIB);
            end
            tests++;
            if (s !== es[i] || co !== ec[i]) begin
                failed++;
                $display("FAIL directed_result[%0d]: sum=%h cout=%b, required %h %b",
                         i, s, co, es[i], ec[i]);
            end
            tests++;
            if (!rl) begin
                failed++;
                $display("FAIL directed_in_ready[%0d]: in_ready rose during RUN, required 0", i);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s;
        logic co;
        int lat;
        bit rl, ok;
        logic [W:0] exp;
        exp = model(16'hA5C3, 16'h3C7E, 1'b1, 1'b0);
        do_op(16'hA5C3, 16'h3C7E, 1'b1, 1'b0, 1'b0, s, co, lat, rl, ok);
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
            tick();
            tests++;
            if (out_valid !== 1'b1 || sum !== exp[W-1:0] || cout !== exp[W] || in_ready !== 1'b0) begin
                failed++;
                $display("FAIL hold[%0d]: valid=%b sum=%h cout=%b in_ready=%b, required 1 %h %b 0",
                         i, out_valid, sum, cout, in_ready, exp[W-1:0], exp[W]);
            end
        end
        in_valid = 1'b0;
        handshake();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL release: valid=%b in_ready=%b busy=%b, required 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_mid_reset();
        a = 16'h7777; b = 16'h1111; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL mid_reset: valid=%b in_ready=%b sum=%h busy=%b, required 0 1 0000 0",
                     out_valid, in_ready, sum, busy);
        end
        // The controller must be usable immediately after the aborted operation
        begin
            logic [W-1:0] s;
            logic co;
            int lat;
            bit rl, ok;
            logic [W:0] exp;
            exp = model(16'h0F0F, 16'h0101, 1'b0, 1'b0);
            do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, s, co, lat, rl, ok);
            tests++;
            if (!ok || s !== exp[W-1:0] || co !== exp[W]) begin
                failed++;
                $display("FAIL post_reset_op: valid=%b sum=%h cout=%b, required 1 %h %b",
                         ok, s, co, exp[W-1:0], exp[W]);
            end
            handshake();
        end
    endtask

    task automatic test_random(input bit toggle, input int n);
        logic [W-1:0] av, bv, s;
        logic ci, sb, co;
        int lat;
        bit rl, ok;
        logic [W:0] exp;
        for (int i = 0; i < n; i++) begin
            av = W'($urandom); bv = W'($urandom);
            ci = 1'($urandom); sb = 1'($urandom);
            if (i % 5 == 0) bv = ~av;
            exp = model(av, bv, ci, sb);
            do_op(av, bv, ci, sb, toggle, s, co, lat, rl, ok);
            tests++;
            if (!ok || lat != NIB || !rl || s !== exp[W-1:0] || co !== exp[W]) begin
                failed++;
                $display("FAIL random%s[%0d]: %h,%h,cin=%b,sub=%b -> valid=%b lat=%0d sum=%h cout=%b, required 1 %0d %h %b",
                         toggle ? "_toggle" : "", i, av, bv, ci, sb, ok, lat, s, co,
                         NIB, exp[W-1:0], exp[W]);
            end
            handshake();
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] s, es;
        logic co;
        int lat;
        bit rl, ok;
        es = SUB_EN ? 16'hFFFE : 16'h000C;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, s, co, lat, rl, ok);
        tests++;
        if (!ok || s !== es || co !== 1'b0) begin
            failed++;
            $display("FAIL sub: valid=%b sum=%h cout=%b, required 1 %h 0", ok, s, co, es);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_random(1'b0, 40);
        test_random(1'b1, 20);
        test_sub();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
